// File: rtl/execute_stage_md.sv
// Execute stage: ALU, addi and address calc from the stage register (1 edge after capture), plus an
// iterative signed mul/div that holds stall for DATA_WIDTH cycles and presents its result on a DONE cycle.
module execute_stage_md #(
  parameter int         DATA_WIDTH = 32,
  parameter int         IMM_WIDTH  = 17,
  parameter logic [4:0] STATUS_REG = 5'd30,
  parameter bit         MD_ENABLE  = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [31:0]           insn_in,
  input  logic [DATA_WIDTH-1:0] rs_val,
  input  logic [DATA_WIDTH-1:0] rt_val,
  output logic                  stall,
  output logic                  out_valid,
  output logic [31:0]           insn_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] rt_out,
  output logic                  not_equal,
  output logic                  less_than
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] FN_ADD = 5'd0, FN_SUB = 5'd1, FN_AND = 5'd2, FN_OR  = 5'd3;
  localparam logic [4:0] FN_SLL = 5'd4, FN_SRA = 5'd5, FN_MUL = 5'd6, FN_DIV = 5'd7;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} md_state_e;

  md_state_e      state_q, state_d;
  logic [31:0]    insn_q, insn_d;
  logic [W-1:0]   rs_q, rs_d, rt_q, rt_d;
  logic           valid_q, valid_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] prod_q, prod_d;

  logic [4:0]                  opcode, aluop, rd, shamt;
  logic                        is_rtype, is_addi, md_in, md_neg, exc, exc_hit;
  logic [31:0]                 sh_amt;
  logic signed [IMM_WIDTH-1:0] imm;
  logic [W-1:0]                imm_ext, mag_rt, mag_in, rem_sh, quo, res;
  logic [W-1:0]                add_sum, sub_dif, addi_sum;
  logic                        add_ovf, sub_ovf, addi_ovf;
  logic [W:0]                  mul_sum, div_diff;
  logic [2*W-1:0]              mul_step, div_step, prod_sgn;
  logic [2:0]                  code;

  assign opcode   = insn_q[31:27];
  assign rd       = insn_q[26:22];
  assign shamt    = insn_q[11:7];
  assign aluop    = insn_q[6:2];
  assign is_rtype = (opcode == OP_RTYPE);
  assign is_addi  = (opcode == OP_ADDI);
  assign imm      = insn_q[IMM_WIDTH-1:0];
  assign imm_ext  = W'(imm);
  assign sh_amt   = 32'(shamt) % W;

  assign add_sum  = rs_q + rt_q;
  assign sub_dif  = rs_q - rt_q;
  assign addi_sum = rs_q + imm_ext;
  assign add_ovf  = (rs_q[W-1] == rt_q[W-1])    && (add_sum[W-1]  != rs_q[W-1]);
  assign sub_ovf  = (rs_q[W-1] != rt_q[W-1])    && (sub_dif[W-1]  != rs_q[W-1]);
  assign addi_ovf = (rs_q[W-1] == imm_ext[W-1]) && (addi_sum[W-1] != rs_q[W-1]);

  // Iteration runs on magnitudes; the sign is reapplied once the DONE cycle is reached.
  assign mag_rt   = rt_q[W-1]   ? -rt_q   : rt_q;
  assign mag_in   = rs_val[W-1] ? -rs_val : rs_val;
  assign md_neg   = rs_q[W-1] ^ rt_q[W-1];
  assign md_in    = MD_ENABLE && in_valid && (insn_in[31:27] == OP_RTYPE) &&
                    ((insn_in[6:2] == FN_MUL) || (insn_in[6:2] == FN_DIV));

  assign mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mag_rt} : '0);
  assign mul_step = {mul_sum, prod_q[W-1:1]};
  assign rem_sh   = prod_q[2*W-2:W-1];
  assign div_diff = {1'b0, rem_sh} - {1'b0, mag_rt};
  assign div_step = div_diff[W] ? {rem_sh, prod_q[W-2:0], 1'b0}
                                : {div_diff[W-1:0], prod_q[W-2:0], 1'b1};
  assign prod_sgn = md_neg ? -prod_q : prod_q;
  assign quo      = md_neg ? -prod_q[W-1:0] : prod_q[W-1:0];

  always_comb begin
    res  = '0;
    exc  = 1'b0;
    code = 3'd0;
    if (is_rtype) begin
      case (aluop)
        FN_ADD: begin res = add_sum; exc = add_ovf; code = 3'd1; end
        FN_SUB: begin res = sub_dif; exc = sub_ovf; code = 3'd3; end
        FN_AND: res = rs_q & rt_q;
        FN_OR:  res = rs_q | rt_q;
        FN_SLL: res = rs_q << sh_amt;
        FN_SRA: res = $signed(rs_q) >>> sh_amt;
        FN_MUL: if (MD_ENABLE) begin
          res  = prod_sgn[W-1:0];
          exc  = (prod_sgn[2*W-1:W] != {W{prod_sgn[W-1]}});
          code = 3'd4;
        end
        FN_DIV: if (MD_ENABLE) begin
          res  = (rt_q == '0) ? '0 : quo;
          exc  = (rt_q == '0);
          code = 3'd5;
        end
        default: res = '0;
      endcase
    end else begin
      res = addi_sum;
      if (is_addi) begin
        exc  = addi_ovf;
        code = 3'd2;
      end
    end
  end

  assign exc_hit   = exc && valid_q && (state_q != BUSY);
  assign stall     = (state_q == BUSY);
  assign out_valid = valid_q && (state_q != BUSY) && !((state_q == DONE) && flush);
  assign insn_out  = exc_hit ? {insn_q[31:27], STATUS_REG, insn_q[21:0]} : insn_q;
  assign data_out  = exc_hit ? W'(code) : (((is_rtype || is_addi) && (rd == 5'd0)) ? '0 : res);
  assign rt_out    = rt_q;
  assign not_equal = (rs_q != rt_q);
  assign less_than = ($signed(rs_q) < $signed(rt_q));

  always_comb begin
    state_d = state_q;
    insn_d  = insn_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    if (flush) begin
      state_d = IDLE;
      insn_d  = '0;
      rs_d    = '0;
      rt_d    = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
      prod_d  = '0;
    end else begin
      if (!stall) begin
        valid_d = in_valid;
        insn_d  = in_valid ? insn_in : '0;
        rs_d    = in_valid ? rs_val  : '0;
        rt_d    = in_valid ? rt_val  : '0;
      end
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (md_in) begin
            state_d = BUSY;
            cnt_d   = CW'(W - 1);
            prod_d  = {{W{1'b0}}, mag_in};
          end
        end
        BUSY: begin
          prod_d = (aluop == FN_DIV) ? div_step : mul_step;
          if (cnt_q == '0) state_d = DONE;
          else             cnt_d   = cnt_q - CW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      insn_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end
endmodule

// File: tb/tb_execute_stage_md.sv
// Bench for execute_stage_md: directed corner cases then random ops against an arithmetic reference model.
module tb_execute_stage_md;
  logic        clock, reset, flush, in_valid;
  logic [31:0] insn_in, rs_val, rt_val;
  logic        stall, out_valid, not_equal, less_than;
  logic [31:0] insn_out, data_out, rt_out;

  int n_tests = 0;
  int n_fail  = 0;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  execute_stage_md dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
    .insn_in(insn_in), .rs_val(rs_val), .rt_val(rt_val),
    .stall(stall), .out_valid(out_valid), .insn_out(insn_out),
    .data_out(data_out), .rt_out(rt_out), .not_equal(not_equal), .less_than(less_than)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] rd, rs, rt, sh, fn);
    return {5'd0, rd, rs, rt, sh, fn, 2'b00};
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      5: return 32'($urandom_range(0, 20));
      6: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Expected result from plain signed 64-bit arithmetic on the architectural rules.
  function automatic void ref_model(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] e_insn, output logic [31:0] e_data);
    logic [4:0]  op, fn;
    int          sh;
    longint      sa, sb, im, r, d;
    logic [31:0] code;
    bit          exc;
    op   = insn[31:27];
    fn   = insn[6:2];
    sh   = int'(insn[11:7]) % 32;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    im   = longint'($signed(insn[16:0]));
    exc  = 1'b0;
    code = 32'd0;
    r    = 0;
    if (op == 5'd0) begin
      case (fn)
        5'd0: begin r = sa + sb; exc = (r > SMAX) || (r < SMIN); code = 32'd1; end
        5'd1: begin r = sa - sb; exc = (r > SMAX) || (r < SMIN); code = 32'd3; end
        5'd2: r = longint'(a & b);
        5'd3: r = longint'(a | b);
        5'd4: r = longint'(a) * (longint'(1) << sh);
        5'd5: begin
          d = longint'(1) << sh;
          r = (sa >= 0) ? sa / d : -((-sa + d - 1) / d);
        end
        5'd6: begin r = sa * sb; exc = (r > SMAX) || (r < SMIN); code = 32'd4; end
        5'd7: begin
          code = 32'd5;
          if (b == 32'd0) begin exc = 1'b1; r = 0; end
          else r = sa / sb;
        end
        default: r = 0;
      endcase
    end else if (op == 5'd5) begin
      r = sa + im; exc = (r > SMAX) || (r < SMIN); code = 32'd2;
    end else begin
      r = sa + im;
    end
    e_data = r[31:0];
    e_insn = insn;
    if ((op == 5'd0 || op == 5'd5) && insn[26:22] == 5'd0) e_data = 32'd0;
    if (exc) begin
      e_insn[26:22] = 5'd30;
      e_data        = code;
    end
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_stall"},     32'(stall),     32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_insn_out"},  insn_out,       32'd0);
    chk({tag, "_data_out"},  data_out,       32'd0);
    chk({tag, "_rt_out"},    rt_out,         32'd0);
    chk({tag, "_ne"},        32'(not_equal), 32'd0);
    chk({tag, "_lt"},        32'(less_than), 32'd0);
  endtask

  // Counts BUSY cycles until stall drops, bounded; out_valid must stay low throughout.
  task automatic wait_md(input string tag);
    int cyc = 0;
    int ov_bad = 0;
    while (stall === 1'b1 && cyc < 40) begin
      if (out_valid !== 1'b0) ov_bad++;
      @(posedge clock); #1;
      cyc++;
    end
    chk({tag, "_busy_cycles"}, 32'(cyc), 32'd32);
    chk({tag, "_busy_no_valid"}, 32'(ov_bad), 32'd0);
  endtask

  task automatic exec(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] e_insn, e_data;
    bit md;
    ref_model(insn, a, b, e_insn, e_data);
    md = (insn[31:27] == 5'd0) && (insn[6:2] == 5'd6 || insn[6:2] == 5'd7);
    in_valid = 1'b1; insn_in = insn; rs_val = a; rt_val = b;
    @(posedge clock); #1;
    if (md) wait_md(tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_stall"},     32'(stall),     32'd0);
    chk({tag, "_insn_out"},  insn_out,       e_insn);
    chk({tag, "_data_out"},  data_out,       e_data);
    chk({tag, "_rt_out"},    rt_out,         b);
    chk({tag, "_ne"},        32'(not_equal), 32'(a != b));
    chk({tag, "_lt"},        32'(less_than), 32'($signed(a) < $signed(b)));
  endtask

  task automatic bubble(input logic [31:0] junk, input string tag);
    in_valid = 1'b0; insn_in = junk; rs_val = $urandom; rt_val = $urandom;
    @(posedge clock); #1;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_insn_out"},  insn_out,       32'd0);
  endtask

  initial begin
    logic [31:0] rinsn;
    int sel;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    insn_in = '0; rs_val = '0; rt_val = '0;
    repeat (2) @(posedge clock);
    #1;
    check_idle("reset");
    reset = 1'b0;

    exec(mk_r(5'd1, 5'd2, 5'd3, 5'd0, 5'd0), 32'd5, 32'd7, "add_5_7");
    exec(mk_r(5'd1, 5'd2, 5'd3, 5'd0, 5'd0), 32'h7FFF_FFFF, 32'd1, "add_ovf");

    // mul -3*7 with the next instruction already waiting at the inputs
    in_valid = 1'b1; insn_in = mk_r(5'd5, 5'd1, 5'd2, 5'd0, 5'd6);
    rs_val = -32'd3; rt_val = 32'd7;
    @(posedge clock); #1;
    chk("mul_capture_stall", 32'(stall), 32'd1);
    insn_in = mk_r(5'd6, 5'd3, 5'd4, 5'd0, 5'd0); rs_val = 32'd10; rt_val = 32'd20;
    wait_md("mul_m3x7");
    chk("mul_done_valid", 32'(out_valid), 32'd1);
    chk("mul_done_data",  data_out, 32'hFFFF_FFEB);
    chk("mul_done_insn",  insn_out, mk_r(5'd5, 5'd1, 5'd2, 5'd0, 5'd6));
    @(posedge clock); #1;
    chk("queued_valid", 32'(out_valid), 32'd1);
    chk("queued_data",  data_out, 32'd30);
    chk("queued_insn",  insn_out, mk_r(5'd6, 5'd3, 5'd4, 5'd0, 5'd0));

    exec(mk_r(5'd7, 5'd1, 5'd2, 5'd0, 5'd7), 32'd7, 32'd0, "div_by_zero");
    exec(mk_r(5'd7, 5'd1, 5'd2, 5'd0, 5'd7), -32'd7, 32'd2, "div_m7_2");
    exec(mk_r(5'd7, 5'd1, 5'd2, 5'd0, 5'd7), 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    exec(mk_r(5'd8, 5'd1, 5'd2, 5'd0, 5'd6), 32'h0001_0000, 32'h0001_0000, "mul_ovf");
    exec(mk_r(5'd0, 5'd1, 5'd2, 5'd0, 5'd3), 32'h1234_0000, 32'h0000_5678, "or_rd0");
    exec(mk_r(5'd0, 5'd1, 5'd2, 5'd0, 5'd1), 32'h8000_0000, 32'd1, "sub_ovf_rd0");
    exec(mk_r(5'd9, 5'd1, 5'd2, 5'd31, 5'd5), 32'h8000_0000, 32'd0, "sra_31");
    bubble(32'hDEAD_BEEF, "bubble");

    // flush arriving on the DONE cycle drops the result and the waiting instruction
    in_valid = 1'b1; insn_in = mk_r(5'd5, 5'd1, 5'd2, 5'd0, 5'd6);
    rs_val = 32'd3; rt_val = 32'd3;
    @(posedge clock); #1;
    insn_in = mk_r(5'd6, 5'd3, 5'd4, 5'd0, 5'd0); rs_val = 32'd1; rt_val = 32'd1;
    wait_md("flush_mul");
    flush = 1'b1;
    #1;
    chk("flush_done_valid", 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    flush = 1'b0;
    check_idle("after_flush");

    // asynchronous reset in the middle of a multiply
    in_valid = 1'b1; insn_in = mk_r(5'd5, 5'd1, 5'd2, 5'd0, 5'd6);
    rs_val = 32'd123; rt_val = 32'd456;
    @(posedge clock); #1;
    repeat (9) begin @(posedge clock); #1; end
    chk("busy10_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    check_idle("reset_busy");
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    exec(mk_i(5'b00101, 5'd4, 5'd0, 17'h1FFFF), 32'd0, 32'd0, "addi_m1");

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        bubble($urandom, $sformatf("rbub%0d", i));
      end else begin
        sel   = $urandom_range(0, 9);
        rinsn = $urandom;
        if (sel < 6) begin
          rinsn[31:27] = 5'd0;
          rinsn[6:2]   = 5'($urandom_range(0, 7));
        end else if (sel < 8) begin
          rinsn[31:27] = 5'b00101;
        end else begin
          rinsn[31:27] = (sel == 8) ? 5'b00111 : 5'b01000;
        end
        exec(rinsn, rnd_val(), rnd_val(), $sformatf("rand%0d", i));
      end
    end

    in_valid = 1'b0;
    @(posedge clock); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
